// File: rtl/led_scan_decoder_pkg.sv
// Shared definitions for the LED scan decoder: mode encodings, the scan
// FSM state type and the polarised one-hot decode helper.
package led_pkg;

  localparam logic [1:0] LED_DIRECT = 2'b00;
  localparam logic [1:0] LED_UP     = 2'b01;
  localparam logic [1:0] LED_DOWN   = 2'b10;
  localparam logic [1:0] LED_BOUNCE = 2'b11;

  // Widest LED vector the decode helper can produce.
  localparam int MAX_OUT = 256;

  // Bounce carries its direction in the state itself.
  typedef enum logic [2:0] {
    ST_DIRECT,
    ST_UP,
    ST_DOWN,
    ST_BOUNCE_UP,
    ST_BOUNCE_DN
  } scan_state_t;

  // Polarised one-hot: bit idx lit, everything else dark; all dark if idx >= n.
  function automatic logic [MAX_OUT-1:0] onehot(input int idx, input int n,
                                                input logic active_low);
    logic [MAX_OUT-1:0] v;
    for (int i = 0; i < MAX_OUT; i++) begin
      v[i] = ((i == idx) && (idx < n)) ? ~active_low : active_low;
    end
    return v;
  endfunction

endpackage

// File: rtl/led_scan_decoder_if.sv
// Control and LED bus between board logic and the scan decoder.
interface led_scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
);
  logic             ENABLE;
  logic [1:0]       MODE;
  logic [SEL_W-1:0] IN;
  logic             LOAD;
  logic [N_OUT-1:0] LED;
  logic [SEL_W-1:0] POS;
  logic             WRAP;

  modport master (output ENABLE, MODE, IN, LOAD, input LED, POS, WRAP);
  modport slave  (input ENABLE, MODE, IN, LOAD, output LED, POS, WRAP);
endinterface

// File: rtl/led_scan_decoder_prescaler.sv
// Scan-step prescaler: counts 0..PRESCALE-1 while enabled, ticks on the last
// count. CLR restarts the count and suppresses the tick in that cycle.
module led_prescaler #(
  parameter int PRESCALE = 4,
  parameter int CNT_W    = $clog2(PRESCALE) + 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign TICK = EN && !CLR && (cnt == LAST);

  // Step counter: clear wins, otherwise count and fold back to 0 on a tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_decoder.sv
// Registered LED decoder: lights one of N_OUT LEDs from a direct index or a
// prescaled scan position (chase-up, chase-down, bounce).
module led_scan_decoder
  import led_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int N_OUT      = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int PRESCALE   = 4,
  parameter int CNT_W      = $clog2(PRESCALE) + 1
) (
  input logic               CLK,
  input logic               RST,
  led_scan_decoder_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST    = SEL_W'(N_OUT - 1);
  localparam logic [SEL_W-1:0] REV_DN  = SEL_W'((N_OUT > 1) ? N_OUT - 2 : 0);
  localparam logic [SEL_W-1:0] REV_UP  = SEL_W'((N_OUT > 1) ? 1 : 0);
  localparam logic [N_OUT-1:0] DARK    = {N_OUT{ACTIVE_LOW != 0}};

  scan_state_t        state, state_n;
  logic [SEL_W-1:0]   pos_q, pos_n;
  logic [N_OUT-1:0]   led_q, led_n;
  logic               wrap_q, wrap_n;
  logic [MAX_OUT-1:0] oh;
  logic               tick, scan, mode_chg, pre_en, pre_clr;

  function automatic logic [1:0] state_mode(input scan_state_t s);
    case (s)
      ST_UP:                     return LED_UP;
      ST_DOWN:                   return LED_DOWN;
      ST_BOUNCE_UP, ST_BOUNCE_DN: return LED_BOUNCE;
      default:                   return LED_DIRECT;
    endcase
  endfunction

  function automatic logic [SEL_W-1:0] clamp(input logic [SEL_W-1:0] p);
    return (p > LAST) ? LAST : p;
  endfunction

  // A mode change is the incoming MODE differing from the registered mode.
  assign scan     = (bus.MODE != LED_DIRECT);
  assign mode_chg = (bus.MODE != state_mode(state));
  assign pre_en   = !bus.ENABLE && scan;
  assign pre_clr  = !bus.ENABLE && (!scan || bus.LOAD || mode_chg);

  led_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (pre_en),
    .CLR  (pre_clr),
    .TICK (tick)
  );

  // Next position, FSM state, wrap pulse and LED decode of the next position.
  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    wrap_n  = 1'b0;
    led_n   = DARK;
    oh      = '0;
    if (!bus.ENABLE) begin
      if (!scan) begin
        state_n = ST_DIRECT;
        pos_n   = bus.IN;
      end else if (bus.LOAD || mode_chg) begin
        pos_n = bus.LOAD ? clamp(bus.IN) : clamp(pos_q);
        if (mode_chg) begin
          case (bus.MODE)
            LED_UP:   state_n = ST_UP;
            LED_DOWN: state_n = ST_DOWN;
            default:  state_n = (pos_n == LAST) ? ST_BOUNCE_DN : ST_BOUNCE_UP;
          endcase
        end
      end else if (tick) begin
        case (state)
          ST_UP: begin
            if (pos_q >= LAST) begin
              pos_n  = '0;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos_q + SEL_W'(1);
            end
          end
          ST_DOWN: begin
            if (pos_q == '0) begin
              pos_n  = LAST;
              wrap_n = 1'b1;
            end else begin
              pos_n = pos_q - SEL_W'(1);
            end
          end
          ST_BOUNCE_UP: begin
            if (pos_q >= LAST) begin
              state_n = ST_BOUNCE_DN;
              pos_n   = REV_DN;
              wrap_n  = 1'b1;
            end else begin
              pos_n = pos_q + SEL_W'(1);
            end
          end
          ST_BOUNCE_DN: begin
            if (pos_q == '0) begin
              state_n = ST_BOUNCE_UP;
              pos_n   = REV_UP;
              wrap_n  = 1'b1;
            end else begin
              pos_n = pos_q - SEL_W'(1);
            end
          end
          default: ;
        endcase
      end
      oh    = onehot(int'(pos_n), N_OUT, ACTIVE_LOW != 0);
      led_n = oh[N_OUT-1:0];
    end
  end

  // State, position, LED and wrap registers; reset leaves all LEDs dark.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_DIRECT;
      pos_q  <= '0;
      led_q  <= DARK;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_n;
      pos_q  <= pos_n;
      led_q  <= led_n;
      wrap_q <= wrap_n;
    end
  end

  assign bus.LED  = led_q;
  assign bus.POS  = pos_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Bench for led_scan_decoder: four configurations share one stimulus stream,
// each checked every cycle against a behavioural model, plus directed checks.
module tb_led_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] din = 3'd0;

  always #5 clk = ~clk;

  led_scan_decoder_if #(.SEL_W(3), .N_OUT(8)) ifa ();
  led_scan_decoder_if #(.SEL_W(3), .N_OUT(6)) ifb ();
  led_scan_decoder_if #(.SEL_W(3), .N_OUT(4)) ifc ();
  led_scan_decoder_if #(.SEL_W(1), .N_OUT(1)) ifd ();

  assign ifa.ENABLE = en;  assign ifa.MODE = mode;  assign ifa.IN = din;     assign ifa.LOAD = load;
  assign ifb.ENABLE = en;  assign ifb.MODE = mode;  assign ifb.IN = din;     assign ifb.LOAD = load;
  assign ifc.ENABLE = en;  assign ifc.MODE = mode;  assign ifc.IN = din;     assign ifc.LOAD = load;
  assign ifd.ENABLE = en;  assign ifd.MODE = mode;  assign ifd.IN = din[0];  assign ifd.LOAD = load;

  led_scan_decoder #(.SEL_W(3), .N_OUT(8), .ACTIVE_LOW(1), .PRESCALE(4))
    dut_a (.CLK(clk), .RST(rst), .bus(ifa.slave));
  led_scan_decoder #(.SEL_W(3), .N_OUT(6), .ACTIVE_LOW(1), .PRESCALE(4))
    dut_b (.CLK(clk), .RST(rst), .bus(ifb.slave));
  led_scan_decoder #(.SEL_W(3), .N_OUT(4), .ACTIVE_LOW(0), .PRESCALE(1))
    dut_c (.CLK(clk), .RST(rst), .bus(ifc.slave));
  led_scan_decoder #(.SEL_W(1), .N_OUT(1), .ACTIVE_LOW(1), .PRESCALE(2))
    dut_d (.CLK(clk), .RST(rst), .bus(ifd.slave));

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  int c_sel [4] = '{3, 3, 3, 1};
  int c_n   [4] = '{8, 6, 4, 1};
  int c_al  [4] = '{1, 1, 0, 1};
  int c_p   [4] = '{4, 4, 1, 2};

  // model state per configuration
  int m_pos [4];
  int m_up  [4];
  int m_cnt [4];
  int m_pm  [4];
  int m_led [4];
  int m_wrap[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 'h%0h want 'h%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int led_of(input int k, input int p);
    int mask, lit;
    mask = (1 << c_n[k]) - 1;
    lit  = (p < c_n[k]) ? (1 << p) : 0;
    return (c_al[k] != 0) ? (mask & ~lit) : lit;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [31:0] obs_led(input int k);
    case (k)
      0: return 32'(ifa.LED);
      1: return 32'(ifb.LED);
      2: return 32'(ifc.LED);
      default: return 32'(ifd.LED);
    endcase
  endfunction

  function automatic logic [31:0] obs_pos(input int k);
    case (k)
      0: return 32'(ifa.POS);
      1: return 32'(ifb.POS);
      2: return 32'(ifc.POS);
      default: return 32'(ifd.POS);
    endcase
  endfunction

  function automatic logic [31:0] obs_wrap(input int k);
    case (k)
      0: return 32'(ifa.WRAP);
      1: return 32'(ifb.WRAP);
      2: return 32'(ifc.WRAP);
      default: return 32'(ifd.WRAP);
    endcase
  endfunction

  // One clock edge of the behavioural model for configuration k.
  task automatic model_step(input int k);
    int n, iv, md;
    bit chg;
    n  = c_n[k];
    iv = int'(din) & ((1 << c_sel[k]) - 1);
    md = int'(mode);
    m_wrap[k] = 0;
    if (rst) begin
      m_pos[k] = 0; m_up[k] = 1; m_cnt[k] = 0; m_pm[k] = 0;
      m_led[k] = led_of(k, n);
    end else if (en) begin
      m_led[k] = led_of(k, n);
    end else if (md == 0) begin
      m_pos[k] = iv; m_cnt[k] = 0; m_pm[k] = 0;
      m_led[k] = led_of(k, m_pos[k]);
    end else begin
      chg = (md != m_pm[k]);
      m_pm[k] = md;
      if (load || chg) begin
        m_pos[k] = load ? imin(iv, n - 1) : imin(m_pos[k], n - 1);
        m_cnt[k] = 0;
        if (chg && md == 3) m_up[k] = (m_pos[k] == n - 1) ? 0 : 1;
      end else if (m_cnt[k] == c_p[k] - 1) begin
        m_cnt[k] = 0;
        if (md == 1) begin
          if (m_pos[k] == n - 1) begin m_pos[k] = 0; m_wrap[k] = 1; end
          else m_pos[k] = m_pos[k] + 1;
        end else if (md == 2) begin
          if (m_pos[k] == 0) begin m_pos[k] = n - 1; m_wrap[k] = 1; end
          else m_pos[k] = m_pos[k] - 1;
        end else if (m_up[k] != 0) begin
          if (m_pos[k] == n - 1) begin
            m_up[k] = 0; m_pos[k] = (n > 1) ? n - 2 : 0; m_wrap[k] = 1;
          end else m_pos[k] = m_pos[k] + 1;
        end else begin
          if (m_pos[k] == 0) begin
            m_up[k] = 1; m_pos[k] = (n > 1) ? 1 : 0; m_wrap[k] = 1;
          end else m_pos[k] = m_pos[k] - 1;
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
      m_led[k] = led_of(k, m_pos[k]);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [2:0] i, input logic ld);
    rst = r; en = e; mode = md; din = i; load = ld;
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("led%0d", k), obs_led(k), 32'(m_led[k]));
      check($sformatf("pos%0d", k), obs_pos(k), 32'(m_pos[k]));
      check($sformatf("wrap%0d", k), obs_wrap(k), 32'(m_wrap[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n, held;
    int bseq[7] = '{1, 2, 3, 2, 1, 0, 1};
    int bwrp[7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [1:0] cur;
    logic pr;

    // reset, then released while disabled
    step(1, 1, 2'd0, 3'd0, 0);
    step(1, 1, 2'd0, 3'd0, 0);
    step(0, 1, 2'd0, 3'd0, 0);
    check("rst_led", obs_led(0), 32'hFF);
    check("rst_pos", obs_pos(0), 32'd0);

    // direct mode and out-of-range index on the 6-LED part
    step(0, 0, 2'd0, 3'd5, 0);
    check("dir5_led", obs_led(0), 32'hDF);
    check("dir5_pos", obs_pos(0), 32'd5);
    step(0, 0, 2'd0, 3'd7, 0);
    check("oor_led", obs_led(1), 32'h3F);
    check("oor_pos", obs_pos(1), 32'd7);
    step(0, 0, 2'd0, 3'd0, 0);
    check("idx0_led", obs_led(1), 32'h3E);

    // chase-up from 6: 7 after 4 cycles, then 0 with a wrap pulse
    step(0, 0, 2'd0, 3'd6, 0);
    step(0, 0, 2'd1, 3'd0, 0);
    n = 0;
    do begin step(0, 0, 2'd1, 3'd0, 0); n++; end while (obs_pos(0) == 6 && n < 20);
    check("up_gap1", n, 4);
    check("up_pos7", obs_pos(0), 32'd7);
    n = 0;
    do begin step(0, 0, 2'd1, 3'd0, 0); n++; end while (obs_pos(0) == 7 && n < 20);
    check("up_gap2", n, 4);
    check("up_wrap_pos", obs_pos(0), 32'd0);
    check("up_wrap", obs_wrap(0), 32'd1);
    step(0, 0, 2'd1, 3'd0, 0);
    check("up_wrap_end", obs_wrap(0), 32'd0);

    // bounce on the 4-LED, PRESCALE=1, active-high part
    step(0, 0, 2'd0, 3'd0, 0);
    step(0, 0, 2'd3, 3'd0, 0);
    for (int j = 0; j < 7; j++) begin
      step(0, 0, 2'd3, 3'd0, 0);
      check($sformatf("bnc_pos%0d", j), obs_pos(2), 32'(bseq[j]));
      check($sformatf("bnc_wrap%0d", j), obs_wrap(2), 32'(bwrp[j]));
      if (bseq[j] == 3) check("bnc_led3", obs_led(2), 32'h8);
    end

    // LOAD on the tick cycle in chase-down
    step(0, 0, 2'd2, 3'd0, 0);
    n = 0;
    while (m_cnt[0] != 3 && n < 10) begin step(0, 0, 2'd2, 3'd0, 0); n++; end
    step(0, 0, 2'd2, 3'd2, 1);
    check("ld_pos", obs_pos(0), 32'd2);
    check("ld_wrap", obs_wrap(0), 32'd0);
    n = 0;
    do begin step(0, 0, 2'd2, 3'd0, 0); n++; end while (obs_pos(0) == 2 && n < 20);
    check("ld_gap", n, 4);
    check("ld_next", obs_pos(0), 32'd1);
    step(0, 0, 2'd2, 3'd7, 1);
    check("ld_clamp", obs_pos(1), 32'd5);
    check("ld_full", obs_pos(0), 32'd7);

    // freeze for 10 cycles during chase, then resume from the held position
    for (int j = 0; j < 6; j++) step(0, 0, 2'd1, 3'd0, 0);
    held = int'(obs_pos(0));
    for (int j = 0; j < 10; j++) begin
      step(0, 1, 2'd1, 3'd3, 1);
      check("frz_led", obs_led(0), 32'hFF);
      check("frz_pos", obs_pos(0), 32'(held));
    end
    n = 0;
    do begin step(0, 0, 2'd1, 3'd0, 0); n++; end while (obs_pos(0) == 32'(held) && n < 10);
    check("resume_pos", obs_pos(0), 32'((held + 1) % 8));

    // reset pulse mid-scan
    step(0, 0, 2'd1, 3'd0, 0);
    step(1, 0, 2'd1, 3'd0, 0);
    check("mid_rst_pos", obs_pos(0), 32'd0);
    check("mid_rst_led", obs_led(0), 32'hFF);
    check("mid_rst_wrap", obs_wrap(0), 32'd0);
    step(0, 0, 2'd0, 3'd0, 0);

    // randomized traffic; MODE only changes on enabled cycles, no LOAD with a mode change
    cur = 2'd0;
    pr = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      logic r, e, ld;
      logic [1:0] md;
      logic [2:0] iv;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 99) < 15);
      md = cur;
      iv = 3'($urandom_range(0, 7));
      ld = 1'b0;
      if (pr) begin
        md = 2'd0;
        e  = 1'b0;
      end else if (!e && $urandom_range(0, 9) == 0) begin
        md = 2'($urandom_range(0, 3));
      end
      if (md == cur && $urandom_range(0, 7) == 0) ld = 1'b1;
      step(r, e, md, iv, ld);
      cur = md;
      pr  = r;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
